// File: rtl/fp_normalize_round.sv
// Normalizes and rounds a raw single-precision adder/multiplier result, then packs it into IEEE-754.
// Multi-cycle: one left shift per cycle for leading-zero normalization, round-to-nearest-even, saturating pack.
module fp_normalize_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [26:0] mant_in,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT_L,
        ROUND,
        PACK,
        DONE
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic               signReg;
    logic               signNext;
    // Signed and two bits wider than the IEEE field so shift-driven underflow and carry-driven overflow stay visible.
    logic signed [9:0]  expReg;
    logic signed [9:0]  expNext;
    logic [26:0]        mantReg;
    logic [26:0]        mantNext;
    logic [31:0]        resultNext;
    logic               overflowNext;
    logic               underflowNext;

    logic               roundUp;
    logic [24:0]        roundSum;

    // Nearest-even: lsb = mant[2], guard = mant[1], sticky = mant[0].
    assign roundUp  = mantReg[1] & (mantReg[0] | mantReg[2]);
    assign roundSum = {1'b0, mantReg[25:2]} + {24'd0, roundUp};

    assign busy = (state == CHECK) || (state == SHIFT_L) || (state == ROUND) || (state == PACK);
    assign done = (state == DONE);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        stateNext     = state;
        signNext      = signReg;
        expNext       = expReg;
        mantNext      = mantReg;
        resultNext    = result;
        overflowNext  = overflow;
        underflowNext = underflow;

        case (state)
            IDLE: begin
                if (start) begin
                    signNext  = sign_in;
                    expNext   = {2'b00, exp_in};
                    mantNext  = mant_in;
                    stateNext = CHECK;
                end
            end

            CHECK: begin
                if (mantReg == 27'd0) begin
                    stateNext = PACK;
                end else if (mantReg[26]) begin
                    // Carry: shift right once, folding the dropped guard into sticky.
                    mantNext  = {1'b0, mantReg[26:2], mantReg[1] | mantReg[0]};
                    expNext   = expReg + 10'sd1;
                    stateNext = ROUND;
                end else if (mantReg[25]) begin
                    stateNext = ROUND;
                end else begin
                    stateNext = SHIFT_L;
                end
            end

            SHIFT_L: begin
                mantNext = {mantReg[25:0], 1'b0};
                expNext  = expReg - 10'sd1;
                // Old bit 24 becomes the hidden bit after this shift.
                if (mantReg[24]) begin
                    stateNext = ROUND;
                end
            end

            ROUND: begin
                if (roundSum[24]) begin
                    mantNext[25:2] = 24'h800000;
                    expNext        = expReg + 10'sd1;
                end else begin
                    mantNext[25:2] = roundSum[23:0];
                end
                stateNext = PACK;
            end

            PACK: begin
                if (mantReg == 27'd0) begin
                    resultNext    = {signReg, 31'd0};
                    overflowNext  = 1'b0;
                    underflowNext = 1'b0;
                end else if (expReg >= 10'sd255) begin
                    resultNext    = {signReg, 8'hFF, 23'd0};
                    overflowNext  = 1'b1;
                    underflowNext = 1'b0;
                end else if (expReg <= 10'sd0) begin
                    resultNext    = {signReg, 31'd0};
                    overflowNext  = 1'b0;
                    underflowNext = 1'b1;
                end else begin
                    resultNext    = {signReg, expReg[7:0], mantReg[24:2]};
                    overflowNext  = 1'b0;
                    underflowNext = 1'b0;
                end
                stateNext = DONE;
            end

            DONE: begin
                // Holding start high must not relaunch; a low cycle re-arms IDLE.
                if (!start) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the working registers are reset too, so a reset mid-operation leaves no stale datapath state.
            state     <= IDLE;
            signReg   <= 1'b0;
            expReg    <= 10'sd0;
            mantReg   <= 27'd0;
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= stateNext;
            signReg   <= signNext;
            expReg    <= expNext;
            mantReg   <= mantNext;
            result    <= resultNext;
            overflow  <= overflowNext;
            underflow <= underflowNext;
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: results, flags, latency, busy/done handshake and reset.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [26:0] mant_in;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        overflow;
    logic        underflow;

    int passCount  = 0;
    int checkCount = 0;

    fp_normalize_round dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Launch one operation, keep start high until done (and holdCycles beyond), then release and check IDLE.
    task automatic runOp(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic [31:0] expRes, input logic expOv, input logic expUn,
                         input int expLat, input int holdCycles);
        int   lat;
        logic busyAll;
        @(negedge clk);
        sign_in = s;
        exp_in  = e;
        mant_in = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        lat     = 0;
        busyAll = busy;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) busyAll = 1'b0;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (expLat >= 0) check({tag, "_latency"}, 32'(lat), 32'(expLat));
        check({tag, "_result"}, result, expRes);
        check({tag, "_flags"}, {30'd0, overflow, underflow}, {30'd0, expOv, expUn});
        check({tag, "_busy_while_working"}, 32'(busyAll), 32'd1);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        if (holdCycles > 0) begin
            repeat (holdCycles) @(posedge clk);
            #1;
            check({tag, "_hold_done"}, {busy, done}, 32'b01);
            check({tag, "_hold_result"}, result, expRes);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_idle_done"}, {busy, done}, 32'b00);
        check({tag, "_idle_result_held"}, result, expRes);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = 8'd0;
        mant_in = 27'd0;
        #3;
        check("reset_outputs", {result}, 32'd0);
        check("reset_ctrl", {28'd0, done, busy, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.0 exactly, no shifting
        runOp("one",        1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 3, 0);
        // Carry in: 2.0
        runOp("carry",      1'b0, 8'd127, 27'h4000000, 32'h40000000, 1'b0, 1'b0, 3, 0);
        // All-ones fraction with guard set rounds over to 2.0
        runOp("round_carry",1'b0, 8'd127, 27'h3FFFFFE, 32'h40000000, 1'b0, 1'b0, 3, 0);
        // 23 left shifts: 4/2^25 * 2^23 = 1.0
        runOp("shift23",    1'b0, 8'd150, 27'h0000004, 32'h3F800000, 1'b0, 1'b0, 26, 0);

        // Reset while shifting: outputs clear immediately
        @(negedge clk);
        sign_in = 1'b0;
        exp_in  = 8'd150;
        mant_in = 27'h0000004;
        start   = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midshift_reset_result", result, 32'd0);
        check("midshift_reset_ctrl", {28'd0, done, busy, overflow, underflow}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh operation after reset; start held through DONE must not relaunch
        runOp("after_reset",1'b0, 8'd127, 27'h2000000, 32'h3F800000, 1'b0, 1'b0, 3, 4);
        // Ties: odd lsb rounds up, even lsb stays
        runOp("tie_odd",    1'b0, 8'd127, 27'h2000006, 32'h3F800002, 1'b0, 1'b0, 3, 0);
        runOp("tie_even",   1'b0, 8'd127, 27'h2000002, 32'h3F800000, 1'b0, 1'b0, 3, 0);
        // Negative value: -2.0
        runOp("negative",   1'b1, 8'd128, 27'h2000000, 32'hC0000000, 1'b0, 1'b0, 3, 0);
        // Overflow via carry and via rounding carry
        runOp("ovf_carry",  1'b0, 8'd254, 27'h4000000, 32'h7F800000, 1'b1, 1'b0, 3, 0);
        runOp("ovf_round",  1'b0, 8'd254, 27'h3FFFFFE, 32'h7F800000, 1'b1, 1'b0, 3, 2);
        // Underflow after shifting below exponent 1, and exponent 0 without shifting
        runOp("unf_shift",  1'b0, 8'd1,   27'h0000004, 32'h00000000, 1'b0, 1'b1, 26, 0);
        runOp("unf_exp0",   1'b0, 8'd0,   27'h2000000, 32'h00000000, 1'b0, 1'b1, 3, 0);
        // Zero mantissa keeps sign, no underflow
        runOp("neg_zero",   1'b1, 8'd100, 27'h0000000, 32'h80000000, 1'b0, 1'b0, -1, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have no parameters; single-precision (8-bit exponent, 23-bit fraction) fixed.
REQ-002 SHALL have these ports, clock and reset first:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous, active-low reset
  start  input  1  operands stable, begin operation (sampled in IDLE only)
  sign_in  input  1  result sign
  exp_in  input  8  biased exponent of unnormalized result
  mant_in  input  27  raw adder/multiplier mantissa: [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky; value = mant_in/2^25 * 2^(exp_in-127)
  result  output  32  IEEE-754 single {sign, exp, fraction}
  done  output  1  result valid
  busy  output  1  high in every state except IDLE and DONE
  overflow  output  1  result saturated to infinity
  underflow  output  1  result flushed to zero

Function
REQ-003 SHALL use states IDLE, CHECK, SHIFT_L, ROUND, PACK, DONE.
REQ-004 SHALL hold the exponent internally as 10-bit signed; mantissa as 27-bit register.
REQ-005 IDLE: start=1 -> capture sign_in, exp_in, mant_in; go CHECK; else stay.
REQ-006 CHECK, mant=0 -> PACK with zero result.
REQ-007 CHECK, mant[26]=1 -> mant={0, mant[26:2], mant[1]|mant[0]}, exp+1; go ROUND.
REQ-008 CHECK, mant[26:25]=01 -> ROUND unchanged.
REQ-009 CHECK, mant[26:25]=00, mant nonzero -> SHIFT_L.
REQ-010 SHIFT_L: one left shift per cycle (mant<<1, zero fill, exp-1); go ROUND the cycle after mant[25] becomes 1; at most 25 shifts.
REQ-011 ROUND (nearest-even): lsb=mant[2], g=mant[1], s=mant[0]; up when g & (s | lsb); up adds 1 to mant[25:2].
REQ-012 SHALL renormalize on rounding carry-out: mant[25:2]=24'h800000, exp+1; go PACK.
REQ-013 PACK, exp>=255 -> result={sign,8'hFF,23'b0}, overflow=1.
REQ-014 PACK, exp<=0 or zero mantissa -> result={sign,31'b0}; underflow=1 only when mantissa nonzero.
REQ-015 PACK, otherwise -> result={sign, exp[7:0], mant[24:2]}; flags 0.
REQ-016 PACK always -> DONE; result and flags registered on that edge.
REQ-017 DONE: done=1; result/flags held; stay while start=1; go IDLE when start=0.
REQ-018 Latency: done rises 3+k rising edges after the edge sampling start (k = SHIFT_L cycles, 0..25).
REQ-019 start while busy or in DONE SHALL be ignored; a new operation requires start low for at least one cycle after done.
REQ-020 result and flags SHALL remain at previous values from IDLE until the next PACK.

Reset
REQ-021 rst_n low SHALL immediately force state IDLE, result=0, done=0, busy=0, overflow=0, underflow=0, internal registers 0, from any state including mid-SHIFT_L.
REQ-022 After rst_n rises, first start sampled high SHALL start a fresh operation.

Verification
REQ-023 sign 0, exp 127, mant 27'h2000000 -> result 3F800000, done after 3 edges, flags 0.
REQ-024 exp 127, mant 27'h4000000 -> 40000000; exp 127, mant 27'h3FFFFFE -> round carry, 40000000.
REQ-025 exp 150, mant 27'h0000004 -> 23 shifts, result 3F800000, done after 26 edges, busy high throughout.
REQ-026 exp 127, mant 27'h2000006 -> 3F800002 (tie, odd, up); mant 27'h2000002 -> 3F800000 (tie, even, down).
REQ-027 exp 254, mant 27'h4000000 -> 7F800000, overflow=1; exp 1, mant 27'h0000004 -> 00000000, underflow=1; sign 1, mant 0 -> 80000000, underflow=0.
REQ-028 rst_n pulsed low during SHIFT_L -> all outputs 0 same cycle; start held high through DONE -> single result, no restart until start toggles low.
